// File: rtl/sdram_arb_if.sv
// Bundle between the three requesters, the slot arbiter and the SDRAM controller.
// The slave modport is the arbiter's view, the master modport the requester/controller side.
interface sdram_arb_if;
    logic        clkref;
    logic        p0_req;
    logic [23:0] p0_addr;
    logic        p0_ack;
    logic        p1_req;
    logic        p1_we;
    logic [23:0] p1_addr;
    logic [1:0]  p1_ds;
    logic [15:0] p1_din;
    logic        p1_ack;
    logic        p2_req;
    logic [23:0] p2_addr;
    logic [1:0]  p2_ds;
    logic [15:0] p2_din;
    logic        p2_ack;
    logic [15:0] dout;
    logic        sd_oe;
    logic        sd_we;
    logic [23:0] sd_addr;
    logic [1:0]  sd_ds;
    logic [15:0] sd_din;
    logic [15:0] sd_dout;
    logic        ready;

    modport slave (
        input  clkref,
        input  p0_req, p0_addr,
        input  p1_req, p1_we, p1_addr, p1_ds, p1_din,
        input  p2_req, p2_addr, p2_ds, p2_din,
        input  sd_dout,
        output p0_ack, p1_ack, p2_ack,
        output dout, sd_oe, sd_we, sd_addr, sd_ds, sd_din, ready
    );

    modport master (
        output clkref,
        output p0_req, p0_addr,
        output p1_req, p1_we, p1_addr, p1_ds, p1_din,
        output p2_req, p2_addr, p2_ds, p2_din,
        output sd_dout,
        input  p0_ack, p1_ack, p2_ack,
        input  dout, sd_oe, sd_we, sd_addr, sd_ds, sd_din, ready
    );
endinterface

// File: rtl/sdram_arb.sv
// Slot-based arbiter: one SDRAM access per 8-clk slot, p0 fixed priority, p1/p2 round-robin,
// forced refresh slot after REFRESH_MAX consecutive grants, startup hold-off after init.
module sdram_arb #(
    parameter int STARTUP_SLOTS = 32,
    parameter int REFRESH_MAX   = 8
) (
    input  logic       clk,
    input  logic       init,
    sdram_arb_if.slave bus
);
    localparam int SW = $clog2(STARTUP_SLOTS + 2);
    localparam int GW = $clog2(REFRESH_MAX + 2);
    localparam logic [SW-1:0] STARTUP_INIT = SW'(STARTUP_SLOTS);
    localparam logic [GW-1:0] GCNT_MAX     = GW'(REFRESH_MAX);

    // Owner of the current slot; NONE means the controller refreshes.
    typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1, OWN_P2} owner_t;

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [1:0]  ds;
        logic [15:0] din;
    } req_t;

    logic [2:0]    ph_q, ph_d;
    logic          last_clkref_q, last_clkref_d;
    owner_t        owner_q, owner_d;
    logic          sd_oe_q, sd_oe_d;
    logic          sd_we_q, sd_we_d;
    logic [23:0]   sd_addr_q, sd_addr_d;
    logic [1:0]    sd_ds_q, sd_ds_d;
    logic [15:0]   sd_din_q, sd_din_d;
    logic [2:0]    ack_q, ack_d;
    logic          last_winner_q, last_winner_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [SW-1:0] startup_q, startup_d;

    logic resync;
    logic decide;
    logic grant_ok;
    req_t sel;

    always_comb begin
        last_clkref_d = bus.clkref;
        resync        = bus.clkref & ~last_clkref_q;
        ph_d          = resync ? 3'd0 : ph_q + 3'd1;
        decide        = (ph_d == 3'd0);
        grant_ok      = (startup_q == '0) && (gcnt_q != GCNT_MAX);

        owner_d       = owner_q;
        sd_oe_d       = sd_oe_q;
        sd_we_d       = sd_we_q;
        sd_addr_d     = sd_addr_q;
        sd_ds_d       = sd_ds_q;
        sd_din_d      = sd_din_q;
        ack_d         = 3'b000;
        last_winner_d = last_winner_q;
        gcnt_d        = gcnt_q;
        startup_d     = startup_q;
        sel.we        = 1'b0;
        sel.addr      = sd_addr_q;
        sel.ds        = sd_ds_q;
        sel.din       = sd_din_q;

        if (decide) begin
            if (startup_q != '0)
                startup_d = startup_q - 1'b1;

            owner_d = OWN_NONE;
            if (grant_ok) begin
                if (bus.p0_req)
                    owner_d = OWN_P0;
                else if (bus.p1_req && (!bus.p2_req || !last_winner_q))
                    owner_d = OWN_P1;
                else if (bus.p2_req)
                    owner_d = OWN_P2;
            end

            case (owner_d)
                OWN_P0: begin
                    sel.addr = bus.p0_addr;
                    sel.ds   = 2'b11;
                end
                OWN_P1: begin
                    sel.we   = bus.p1_we;
                    sel.addr = bus.p1_addr;
                    sel.ds   = bus.p1_ds;
                    sel.din  = bus.p1_din;
                end
                OWN_P2: begin
                    sel.we   = 1'b1;
                    sel.addr = bus.p2_addr;
                    sel.ds   = bus.p2_ds;
                    sel.din  = bus.p2_din;
                end
                default: ;
            endcase

            // Idle slots leave the address/data lines where they were.
            sd_addr_d = sel.addr;
            sd_ds_d   = sel.ds;
            sd_din_d  = sel.din;
            sd_oe_d   = (owner_d != OWN_NONE) && !sel.we;
            sd_we_d   = (owner_d != OWN_NONE) &&  sel.we;

            if (owner_d == OWN_P1) last_winner_d = 1'b1;
            if (owner_d == OWN_P2) last_winner_d = 1'b0;
            gcnt_d = (owner_d == OWN_NONE) ? '0 : gcnt_q + 1'b1;
        end else if (ph_d == 3'd6) begin
            // A resync before this point replaces the slot, so no ack is ever issued for it.
            case (owner_q)
                OWN_P0:  ack_d = 3'b001;
                OWN_P1:  ack_d = 3'b010;
                OWN_P2:  ack_d = 3'b100;
                default: ack_d = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            ph_q          <= 3'd0;
            last_clkref_q <= 1'b0;
            owner_q       <= OWN_NONE;
            sd_oe_q       <= 1'b0;
            sd_we_q       <= 1'b0;
            sd_addr_q     <= '0;
            sd_ds_q       <= '0;
            sd_din_q      <= '0;
            ack_q         <= 3'b000;
            last_winner_q <= 1'b0;
            gcnt_q        <= '0;
            startup_q     <= STARTUP_INIT;
        end else begin
            ph_q          <= ph_d;
            last_clkref_q <= last_clkref_d;
            owner_q       <= owner_d;
            sd_oe_q       <= sd_oe_d;
            sd_we_q       <= sd_we_d;
            sd_addr_q     <= sd_addr_d;
            sd_ds_q       <= sd_ds_d;
            sd_din_q      <= sd_din_d;
            ack_q         <= ack_d;
            last_winner_q <= last_winner_d;
            gcnt_q        <= gcnt_d;
            startup_q     <= startup_d;
        end
    end

    assign bus.p0_ack  = ack_q[0];
    assign bus.p1_ack  = ack_q[1];
    assign bus.p2_ack  = ack_q[2];
    assign bus.sd_oe   = sd_oe_q;
    assign bus.sd_we   = sd_we_q;
    assign bus.sd_addr = sd_addr_q;
    assign bus.sd_ds   = sd_ds_q;
    assign bus.sd_din  = sd_din_q;
    assign bus.dout    = bus.sd_dout;
    assign bus.ready   = (startup_q == '0);
endmodule

// File: tb/tb_sdram_arb.sv
// Slot-level scoreboard bench for sdram_arb: the stimulus process models each slot decision
// and queues expected acks; a negedge monitor compares DUT outputs against the model.
module tb_sdram_arb;
    localparam int STARTUP = 32;
    localparam int RMAX    = 8;

    typedef struct {
        int          port;
        logic        we;
        logic [23:0] addr;
        logic [1:0]  ds;
        logic [15:0] din;
    } exp_t;

    logic clk = 1'b0;
    logic init;
    sdram_arb_if bus();

    sdram_arb #(.STARTUP_SLOTS(STARTUP), .REFRESH_MAX(RMAX)) dut (
        .clk  (clk),
        .init (init),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Controller stand-in: read data is a fixed function of the address.
    assign bus.sd_dout = bus.sd_oe ? (bus.sd_addr[15:0] ^ 16'h3C5A) : 16'h0000;

    int checks = 0;
    int errors = 0;
    int pos    = 0;

    exp_t q[$];

    logic [2:0]  req, we, hold_mask, auto_mask;
    logic [23:0] addr [3];
    logic [1:0]  ds   [3];
    logic [15:0] din  [3];

    int          m_startup, m_run, m_rr_last;
    logic        m_oe, m_we;
    logic [23:0] m_addr;
    logic [1:0]  m_ds;
    logic [15:0] m_din;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive();
        bus.p0_req  = req[0];
        bus.p0_addr = addr[0];
        bus.p1_req  = req[1];
        bus.p1_we   = we[1];
        bus.p1_addr = addr[1];
        bus.p1_ds   = ds[1];
        bus.p1_din  = din[1];
        bus.p2_req  = req[2];
        bus.p2_addr = addr[2];
        bus.p2_ds   = ds[2];
        bus.p2_din  = din[2];
    endtask

    task automatic set_req(input int p, input logic w, input logic [23:0] a,
                           input logic [1:0] d, input logic [15:0] di);
        req[p]  = 1'b1;
        we[p]   = w;
        addr[p] = a;
        ds[p]   = d;
        din[p]  = di;
        drive();
    endtask

    task automatic model_reset();
        m_startup = STARTUP;
        m_run     = 0;
        m_rr_last = 2;
        m_oe      = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_ds      = '0;
        m_din     = '0;
    endtask

    // One slot decision from the arbitration rules; queues an ack only for full-length slots.
    task automatic decide(input int len, output int w);
        exp_t e;
        w = -1;
        if (m_startup > 0) m_startup--;
        else if (m_run < RMAX) begin
            if (req[0]) w = 0;
            else if (req[1] && req[2]) w = (m_rr_last == 1) ? 2 : 1;
            else if (req[1]) w = 1;
            else if (req[2]) w = 2;
        end
        if (w < 0) begin
            m_run = 0;
            m_oe  = 1'b0;
            m_we  = 1'b0;
        end else begin
            m_run++;
            m_addr = addr[w];
            m_ds   = (w == 0) ? 2'b11 : ds[w];
            if (w != 0) m_din = din[w];
            m_oe = !we[w];
            m_we = we[w];
            if (w != 0) m_rr_last = w;
            e.port = w;
            e.we   = we[w];
            e.addr = m_addr;
            e.ds   = m_ds;
            e.din  = m_din;
            if (len == 8) q.push_back(e);
        end
    endtask

    task automatic reissue();
        for (int p = 0; p < 3; p++)
            if (auto_mask[p] && !req[p] && $urandom_range(0, 1) == 1)
                set_req(p, (p == 2) ? 1'b1 : ((p == 1) ? 1'($urandom) : 1'b0),
                        24'($urandom), 2'($urandom), 16'($urandom));
        drive();
    endtask

    // After init release the DUT free-runs ph 0..7; the first decision is the wrap.
    task automatic pre_slot();
        for (int k = 1; k < 8; k++) begin
            @(posedge clk);
            #1;
            pos = k;
        end
        reissue();
        bus.clkref = 1'b1;
    endtask

    // Entered just before a decision edge with clkref already high; len < 7 ends in a resync.
    task automatic run_slot(input int len, input int rst_at);
        int w;
        w = -1;
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            pos = k;
            if (k == 0) begin
                bus.clkref = 1'b0;
                decide(len, w);
            end
            if (k == rst_at) begin
                init = 1'b1;
                q.delete();
                model_reset();
                repeat (3) @(posedge clk);
                #1;
                init = 1'b0;
                pos  = 0;
                pre_slot();
                return;
            end
            if (k == len - 1) begin
                if (len == 8 && w >= 0 && !hold_mask[w]) req[w] = 1'b0;
                reissue();
                bus.clkref = 1'b1;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && (req != 3'b000); i++) run_slot(8, -1);
        run_slot(8, -1);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [2:0] acks;
        int         ap;
        forever begin
            @(negedge clk);
            acks = {bus.p2_ack, bus.p1_ack, bus.p0_ack};
            if (init) begin
                chk("rst_oe_we", {bus.sd_oe, bus.sd_we}, 0);
                chk("rst_addr", bus.sd_addr, 0);
                chk("rst_ds_din", {bus.sd_ds, bus.sd_din}, 0);
                chk("rst_ack_ready", {acks, bus.ready}, 0);
            end else begin
                chk("sd_oe", bus.sd_oe, m_oe);
                chk("sd_we", bus.sd_we, m_we);
                chk("sd_addr", bus.sd_addr, m_addr);
                chk("sd_ds", bus.sd_ds, m_ds);
                chk("sd_din", bus.sd_din, m_din);
                chk("ready", bus.ready, (m_startup == 0));
                if (acks != 3'b000) begin
                    chk("ack_onehot", $countones(acks), 1);
                    chk("ack_phase", pos, 6);
                    if (q.size() == 0) chk("ack_unexpected", acks, 0);
                    else begin
                        e  = q.pop_front();
                        ap = acks[0] ? 0 : (acks[1] ? 1 : 2);
                        chk("ack_port", ap, e.port);
                        chk("ack_addr", bus.sd_addr, e.addr);
                        chk("ack_ds", bus.sd_ds, e.ds);
                        chk("ack_din", bus.sd_din, e.din);
                        chk("ack_dir", {bus.sd_oe, bus.sd_we}, e.we ? 2'b01 : 2'b10);
                        if (!e.we) chk("rd_data", bus.dout, e.addr[15:0] ^ 16'h3C5A);
                    end
                end else if (pos == 7) begin
                    chk("ack_missing", q.size(), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int len;
        init       = 1'b1;
        bus.clkref = 1'b0;
        req        = '0;
        we         = '0;
        hold_mask  = '0;
        auto_mask  = '0;
        for (int p = 0; p < 3; p++) begin
            addr[p] = '0;
            ds[p]   = '0;
            din[p]  = '0;
        end
        drive();
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        // Startup: p1 read waits out the hold-off and is granted in slot 33.
        set_req(1, 1'b0, 24'h000100, 2'b11, 16'h0000);
        init = 1'b0;
        pos  = 0;
        pre_slot();
        repeat (STARTUP + 1) run_slot(8, -1);

        // Write path on p2.
        set_req(2, 1'b1, 24'h123456, 2'b01, 16'hA55A);
        run_slot(8, -1);

        // Priority: p0 first, then p1/p2 alternate while both keep requesting.
        hold_mask = 3'b110;
        set_req(0, 1'b0, 24'h0ABCDE, 2'b11, 16'h0000);
        set_req(1, 1'b1, 24'h000200, 2'b10, 16'h1234);
        set_req(2, 1'b1, 24'h300000, 2'b11, 16'hBEEF);
        repeat (4) run_slot(8, -1);
        hold_mask = 3'b000;
        drain();

        // Refresh: p0 held continuously.
        hold_mask = 3'b001;
        set_req(0, 1'b0, 24'h000040, 2'b11, 16'h0000);
        repeat (20) run_slot(8, -1);
        hold_mask = 3'b000;
        drain();

        // Resync at ph 3 truncates the p1 read; it is re-granted next slot.
        set_req(1, 1'b0, 24'h000777, 2'b11, 16'h0000);
        run_slot(4, -1);
        run_slot(8, -1);

        // init pulsed at ph 4 of a p1 read, then a full startup again.
        set_req(1, 1'b0, 24'h000888, 2'b11, 16'h0000);
        run_slot(8, 4);
        repeat (STARTUP + 1) run_slot(8, -1);

        // Random traffic with occasional truncated slots.
        auto_mask = 3'b111;
        repeat (150) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 6)) : 8;
            run_slot(len, -1);
        end
        auto_mask = 3'b000;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameter STARTUP_SLOTS, default 32: slots after init release during which no access is granted.
REQ-002 Parameter REFRESH_MAX, default 8: maximum consecutive granted slots before a forced idle (refresh) slot.
REQ-003 clk  in  1  SDRAM clock, same clock as the SDRAM controller.
REQ-004 init  in  1  asynchronous active-high reset.
REQ-005 clkref  in  1  slot reference; its rising edge starts an 8-clk slot.
REQ-006 p0_req / p0_addr / p0_ack  in 1 / in 24 / out 1  video port, read-only, word address.
REQ-007 p1_req / p1_we / p1_addr / p1_ds / p1_din / p1_ack  in 1 / in 1 / in 24 / in 2 / in 16 / out 1  CPU port, read or write.
REQ-008 p2_req / p2_addr / p2_ds / p2_din / p2_ack  in 1 / in 24 / in 2 / in 16 / out 1  download port, write-only.
REQ-009 dout  out 16  read data, wired directly from sd_dout.
REQ-010 sd_oe / sd_we / sd_addr / sd_ds / sd_din  out 1 / 1 / 24 / 2 / 16  request to the SDRAM controller.
REQ-011 sd_dout  in 16  read data from the SDRAM controller.
REQ-012 ready  out 1  high once the startup window has elapsed.

Function
REQ-013 Phase counter ph[2:0] and register last_clkref: ph increments every clk; ph loads 0 on the edge where last_clkref==0 and clkref==1, so ph matches the controller's cycle counter exactly.
REQ-014 Decision edge = any clk edge at which ph becomes 0, whether by wrap from 7 or by clkref resync; all sd_* outputs are registered only at decision edges and stay stable for the whole slot.
REQ-015 At a decision edge, requests are sampled and at most one port is granted; sd_oe=1,sd_we=0 for reads, sd_oe=0,sd_we=1 for writes.
REQ-016 Priority: p0 highest; between p1 and p2 round-robin via a last_winner bit, with the port not granted most recently winning when both are pending; last_winner updates only on p1/p2 grants.
REQ-017 Address, ds and din of the granted port are copied to sd_addr, sd_ds and sd_din; a p0 grant drives sd_ds=2'b11.
REQ-018 No grant (no request, startup, or forced refresh): sd_oe=sd_we=0, so the controller performs auto-refresh; sd_addr, sd_ds and sd_din hold their previous values.
REQ-019 Consecutive-grant counter: increments on each granted slot and clears on each idle slot; when it equals REFRESH_MAX, the next slot is forced idle regardless of requests.
REQ-020 Ack: the granted port's ack is registered high at the edge where ph goes 5->6 and is high for exactly one clk (ph==6); for reads, dout is valid in that clk and holds until the next read completes.
REQ-021 Requester handshake: hold req and all request fields stable until ack, and drop req at the edge that ends the ack clk; req still high at the next decision edge counts as a new request.
REQ-022 Truncated slot: if a clkref resync makes ph return to 0 before ph reaches 6, no ack is issued for that slot and the request stays pending for re-arbitration.
REQ-023 Startup counter: loads STARTUP_SLOTS on init and decrements at each decision edge until 0; ready=1 and grants are permitted only when the counter is 0.
REQ-024 At most one ack is high in any clk.

Reset
REQ-025 While init=1, asynchronously: ph=0, last_clkref=0, sd_oe=sd_we=0, sd_addr=0, sd_ds=0, sd_din=0, all acks=0, last_winner=0 (p1 favoured next), grant counter=0, startup counter=STARTUP_SLOTS, ready=0.
REQ-026 Init asserted mid-slot aborts that slot with no ack; after release, normal arbitration resumes only after STARTUP_SLOTS decision edges.

Verification
REQ-027 Startup: release init, p1_req=1 read at 0x000100 -> sd_oe=0 for 32 slots, ready rises, grant in slot 33, p1_ack at ph 6.
REQ-028 Priority: p0, p1 and p2 requesting in the same slot -> p0 granted; after p0 drops, p1 and p2 alternate p1, p2, p1.
REQ-029 Write path: p2 writes din=0xA55A, ds=2'b01, addr=0x123456 -> sd_we=1, sd_oe=0, sd_din=0xA55A, sd_ds=01, sd_addr=0x123456 for all 8 clks; p2_ack high only at ph 6.
REQ-030 Refresh: p0_req held high continuously -> 8 granted slots, then 1 idle slot with sd_oe=sd_we=0, then repeat.
REQ-031 Resync: clkref rising edge forced at ph 3 during a p1 read -> no p1_ack, new decision edge, and p1 re-granted.
REQ-032 Mid-slot reset: init pulsed at ph 4 of a p1 read -> all outputs at reset values immediately, no ack, ready=0.
